// File: rtl/melody_sequencer.sv
// Plays a note table from a synchronous ROM through the Music tone player, one note at a time,
// with a forced silent gap between notes, rest muting and optional looping of the score.
module melody_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              note_en,
    output logic [2:0]        scale,
    output logic [10:0]       play_time,
    input  logic              note_finish,
    input  logic              beep_in,
    output logic              beep_out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic             mute;
    logic             fin_s1, fin_s2;
    logic [1:0]       en_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic addr_zero, addr_inc, load_note, play_end;
    logic fin_ok, gap_last, addr_max, rom_end;

    assign rom_end  = rom_data[15];
    assign addr_max = &rom_addr;
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    // A finish is trusted only after note_en has been high for two cycles, which flushes
    // any level left in the synchroniser from the previous note.
    assign fin_ok   = (state == PLAY) && en_cnt[1] && fin_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        addr_zero = 1'b0;
        addr_inc  = 1'b0;
        load_note = 1'b0;
        play_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = FETCH;
                    addr_zero = 1'b1;
                end
            end
            FETCH: state_nx = LATCH;
            LATCH: begin
                if (rom_end) begin
                    // An END at address 0 would spin forever if looped, so it always finishes.
                    if ((rom_addr == '0) || !loop) begin
                        state_nx = DONE;
                    end else begin
                        state_nx  = FETCH;
                        addr_zero = 1'b1;
                    end
                end else begin
                    state_nx  = PLAY;
                    load_note = 1'b1;
                end
            end
            PLAY: begin
                if (fin_ok) begin
                    state_nx = GAP;
                    play_end = 1'b1;
                end
            end
            GAP: begin
                if (gap_last) begin
                    if (addr_max) begin
                        addr_zero = 1'b1;
                        state_nx  = loop ? FETCH : DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_nx = FETCH;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx  = IDLE;
            addr_zero = 1'b1;
            addr_inc  = 1'b0;
            load_note = 1'b0;
            play_end  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            note_en   <= 1'b0;
            scale     <= 3'd0;
            play_time <= 11'd0;
            mute      <= 1'b0;
        end else begin
            if (addr_zero)     rom_addr <= '0;
            else if (addr_inc) rom_addr <= rom_addr + ADDR_W'(1);

            if (stop || play_end) begin
                note_en <= 1'b0;
                mute    <= 1'b0;
            end else if (load_note) begin
                note_en   <= 1'b1;
                mute      <= rom_data[14];
                scale     <= rom_data[13:11];
                play_time <= rom_data[10:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_s1  <= 1'b0;
            fin_s2  <= 1'b0;
            en_cnt  <= 2'd0;
            gap_cnt <= '0;
        end else begin
            fin_s1 <= note_finish;
            fin_s2 <= fin_s1;
            if (state != PLAY)  en_cnt <= 2'd0;
            else if (!en_cnt[1]) en_cnt <= en_cnt + 2'd1;
            if (state != GAP) gap_cnt <= '0;
            else              gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    assign beep_out  = beep_in & ~mute;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomised bench for melody_sequencer: a ROM model, a behavioural tone player and a
// score walker that predicts the note and address sequence from the note-table rules.
module tb_melody_sequencer;

    localparam int ADDR_W     = 3;
    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 4;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [15:0] END_ENTRY = 16'h8000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data = 16'd0;
    logic              note_en;
    logic [2:0]        scale;
    logic [10:0]       play_time;
    logic              note_finish = 1'b0;
    logic              beep_in = 1'b0;
    logic              beep_out;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;

    logic [15:0]       rom [DEPTH];
    logic [15:0]       exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    int checks = 0;
    int errors = 0;
    int notes_seen = 0;
    int done_cnt = 0;

    melody_sequencer #(.ADDR_W(ADDR_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_en(note_en), .scale(scale),
        .play_time(play_time), .note_finish(note_finish), .beep_in(beep_in),
        .beep_out(beep_out), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // synchronous ROM, one cycle read latency
    always @(posedge clk) rom_data <= rom[rom_addr];

    // tone player: finish rises once note_en has been high for play_time cycles
    initial begin
        int pcnt;
        pcnt = 0;
        forever begin
            @(negedge clk);
            if (!note_en) begin
                pcnt = 0;
                note_finish = 1'b0;
            end else begin
                pcnt++;
                note_finish = (pcnt >= int'(play_time));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2 beep_in = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // score walker: each pass runs from address 0 to an END entry or the address wrap
    task automatic build_expect(input int passes);
        int  addr;
        bit  halt;
        halt = 0;
        for (int p = 0; p < passes && !halt; p++) begin
            addr = 0;
            while (addr < DEPTH) begin
                addr_q.push_back(addr[ADDR_W-1:0]);
                if (rom[addr][15]) begin
                    if (addr == 0) halt = 1;
                    break;
                end
                exp_q.push_back(rom[addr]);
                addr++;
            end
        end
    endtask

    function automatic logic [15:0] mk_note(input logic rest, input logic [2:0] sc,
                                            input logic [10:0] pt);
        return {1'b0, rest, sc, pt};
    endfunction

    function automatic logic [15:0] rand_note();
        return mk_note(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                       11'($urandom_range(1, 12)));
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic check_sb_empty(input string tag);
        check({tag, "_notes_left"}, exp_q.size(), 0);
        check({tag, "_addrs_left"}, addr_q.size(), 0);
    endtask

    // monitor / scoreboard
    logic [15:0] cur = 16'd0;
    logic        cur_rest = 1'b0;
    logic        en_d = 1'b0;
    logic [2:0]  st_d = S_IDLE;
    int          hi_cnt = 0;
    int          gap_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_d = 1'b0; st_d = S_IDLE; cur_rest = 1'b0; hi_cnt = 0; gap_run = 0;
        end else begin
            if (note_en && !en_d) begin
                notes_seen++;
                if (exp_q.size() == 0) begin
                    check("extra_note", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("scale", 32'(scale), 32'(cur[13:11]));
                    check("play_time", 32'(play_time), 32'(cur[10:0]));
                end
                cur_rest = cur[14];
                hi_cnt = 1;
            end else if (note_en) begin
                hi_cnt++;
            end
            // finish needs play_time cycles plus two synchroniser cycles
            if (!note_en && en_d && dbg_state == S_GAP)
                check("note_len", hi_cnt, int'(cur[10:0]) + 2);
            check("beep_out", 32'(beep_out), 32'(beep_in & ~(note_en & cur_rest)));
            if (dbg_state == S_LATCH) begin
                if (addr_q.size() == 0) check("extra_fetch", 1, 0);
                else check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
            end
            if (dbg_state == S_GAP) begin
                gap_run++;
            end else begin
                if (st_d == S_GAP && dbg_state != S_IDLE) check("gap_len", gap_run, GAP_CYCLES);
                gap_run = 0;
            end
            if (done) done_cnt++;
            en_d = note_en;
            st_d = dbg_state;
        end
    end

    // stimulus
    initial begin
        int d0, n, target;
        for (int a = 0; a < DEPTH; a++) rom[a] = END_ENTRY;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_note_en", 32'(note_en), 0);
        check("rst_scale", 32'(scale), 0);
        check("rst_play_time", 32'(play_time), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // two notes then END, with start latency
        rom[0] = mk_note(1'b0, 3'd0, 11'd10);
        rom[1] = mk_note(1'b0, 3'd2, 11'd5);
        rom[2] = END_ENTRY;
        clear_sb(); build_expect(1); d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        check("lat_fetch_en", 32'(note_en), 0);
        check("lat_fetch_busy", 32'(busy), 1);
        @(negedge clk);
        check("lat_latch_en", 32'(note_en), 0);
        @(negedge clk);
        check("lat_play_en", 32'(note_en), 1);
        wait_idle(2000);
        check("t1_done", done_cnt - d0, 1);
        check_sb_empty("t1");

        // rest entry silences beep_out, the next note does not
        rom[0] = mk_note(1'b1, 3'd4, 11'd20);
        rom[1] = mk_note(1'b0, 3'd1, 11'd6);
        rom[2] = END_ENTRY;
        clear_sb(); build_expect(1); d0 = done_cnt;
        pulse_start();
        wait_idle(2000);
        check("t2_done", done_cnt - d0, 1);
        check_sb_empty("t2");

        // looping two-note score, loop dropped during the third pass
        rom[0] = rand_note();
        rom[1] = rand_note();
        rom[2] = END_ENTRY | 16'($urandom_range(0, 16'h7fff));
        clear_sb(); build_expect(3); d0 = done_cnt;
        loop = 1'b1;
        target = notes_seen + 5;
        pulse_start();
        n = 0;
        while (notes_seen < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("loop_wait", 32'(notes_seen >= target), 1);
        check("loop_no_done", done_cnt - d0, 0);
        loop = 1'b0;
        wait_idle(2000);
        check("t3_done", done_cnt - d0, 1);
        check_sb_empty("t3");

        // stop mid-PLAY, then start together with stop in IDLE
        rom[0] = mk_note(1'b0, 3'd3, 11'd20);
        rom[1] = mk_note(1'b0, 3'd5, 11'd4);
        rom[2] = END_ENTRY;
        clear_sb(); build_expect(1); d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!note_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("stop_note_en", 32'(note_en), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_rom_addr", 32'(rom_addr), 0);
        clear_sb();
        @(posedge clk);
        #1 begin start = 1'b1; stop = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; stop = 1'b0; end
        repeat (3) begin
            @(negedge clk);
            check("start_stop_busy", 32'(busy), 0);
        end
        check("stop_no_done", done_cnt - d0, 0);

        // END at address 0 with loop=1: FETCH, LATCH, DONE only
        for (int a = 0; a < DEPTH; a++) rom[a] = END_ENTRY;
        clear_sb(); build_expect(1); d0 = done_cnt;
        loop = 1'b1;
        pulse_start();
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("end0_busy_cycles", n, 3);
        check("end0_done", done_cnt - d0, 1);
        check_sb_empty("t5");
        loop = 1'b0;

        // asynchronous reset in the second gap, then replay from address 0
        for (int a = 0; a < 3; a++) rom[a] = rand_note();
        rom[3] = END_ENTRY;
        clear_sb(); build_expect(1);
        pulse_start();
        n = 0;
        while (!(dbg_state == S_GAP && rom_addr == 3'd1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("gap_wait", 32'(dbg_state), 32'(S_GAP));
        #1 rst_n = 1'b0;
        #1;
        check("arst_note_en", 32'(note_en), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rom_addr", 32'(rom_addr), 0);
        check("arst_scale", 32'(scale), 0);
        check("arst_play_time", 32'(play_time), 0);
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_sb(); build_expect(1); d0 = done_cnt;
        pulse_start();
        wait_idle(3000);
        check("t6_done", done_cnt - d0, 1);
        check_sb_empty("t6");

        // random scores, including full tables that end by address wrap
        for (int it = 0; it < 8; it++) begin
            int len;
            len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
            for (int a = 0; a < DEPTH; a++) rom[a] = (a < len) ? rand_note() : END_ENTRY;
            clear_sb(); build_expect(1); d0 = done_cnt;
            pulse_start();
            wait_idle(5000);
            check("rand_done", done_cnt - d0, 1);
            check_sb_empty("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
